// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the cpu_mc multi-cycle core: opcodes, instruction
// field positions, FSM state encoding and small opcode classifiers.
package cpu_mc_pkg;

  // Opcodes (instruction bits [31:28]); 9..14 are undefined
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_LDR  = 4'd5;
  localparam logic [3:0] OP_STR  = 4'd6;
  localparam logic [3:0] OP_B    = 4'd7;
  localparam logic [3:0] OP_CBZ  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  // Instruction field positions
  localparam int OP_LSB  = 28;
  localparam int RD_LSB  = 23;
  localparam int RN_LSB  = 18;
  localparam int RM_LSB  = 13;
  localparam int IMM_W   = 12;
  localparam int OFF24_W = 24;
  localparam int OFF18_W = 18;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  // Opcodes whose EXEC cycle writes an ALU result to rd
  function automatic logic op_is_alu(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  // Undefined opcodes: they stop the core and are not counted as retired
  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op >= 4'd9) && (op <= 4'd14);
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file for cpu_mc: NREGS x DATA_WIDTH, two asynchronous read ports,
// one synchronous write port. Register 0 is never written and reads as zero.
// The whole file is cleared while resetn is low.
module cpu_regfile
  import cpu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NREGS      = 32,
  localparam int RW        = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [RW-1:0]         ra_addr_i,
  output logic [DATA_WIDTH-1:0] ra_data_o,
  input  logic [RW-1:0]         rb_addr_i,
  output logic [DATA_WIDTH-1:0] rb_data_o,
  input  logic                  we_i,
  input  logic [RW-1:0]         wa_i,
  input  logic [DATA_WIDTH-1:0] wd_i
);

  logic [DATA_WIDTH-1:0] regs_q [NREGS];

  // Clear on reset, otherwise write rd unless it is the zero register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];

endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle FETCH/DECODE/EXEC/MEM core with host code-load port,
// run/pause control and debug outputs. Code and data memories are inferred
// block RAMs with registered reads.
// Optional feature macro: CPU_MC_RETIRE_CNT_EN (retired-instruction counter;
// when undefined retired_cnt is tied to zero).
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CODE_WORDS = 512,
  parameter int DATA_WORDS = 512,
  parameter int NREGS      = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          run,
  input  logic                          code_we,
  input  logic [$clog2(CODE_WORDS)-1:0] code_waddr,
  input  logic [31:0]                   code_wdata,
  output logic                          halted,
  output logic                          illegal,
  output logic [31:0]                   retired_cnt,
  output logic                          led,
  output logic [7:0]                    debug_port1,
  output logic [7:0]                    debug_port2,
  output logic [7:0]                    debug_port3
);

  localparam int PW = $clog2(CODE_WORDS);
  localparam int DW = $clog2(DATA_WORDS);
  localparam int RW = $clog2(NREGS);

  state_e                state_q;
  logic [PW-1:0]         pc_q;
  logic [31:0]           instr_q;
  logic                  halted_q;
  logic                  illegal_q;
  logic [7:0]            load_q;

  logic [31:0]           code_mem [CODE_WORDS];
  logic [31:0]           code_rdata_q;
  logic [DATA_WIDTH-1:0] data_mem [DATA_WORDS];
  logic [DATA_WIDTH-1:0] dmem_rdata_q;

  // Decoded fields of the instruction in flight
  logic [3:0]            op;
  logic [RW-1:0]         rd_idx, rn_idx, rm_idx;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [PW-1:0]         pc_inc, pc_b, pc_cbz;

  assign op      = instr_q[31:OP_LSB];
  assign rd_idx  = instr_q[RD_LSB +: RW];
  assign rn_idx  = instr_q[RN_LSB +: RW];
  assign rm_idx  = instr_q[RM_LSB +: RW];
  assign imm_ext = DATA_WIDTH'(instr_q[IMM_W-1:0]);
  assign pc_inc  = pc_q + PW'(1);
  // Sign-extended offsets reduced to PW bits give modulo-CODE_WORDS targets
  assign pc_b    = pc_q + PW'($signed(instr_q[OFF24_W-1:0]));
  assign pc_cbz  = pc_q + PW'($signed(instr_q[OFF18_W-1:0]));

  // Register file: port A reads rn, port B reads rd for STR/CBZ and rm otherwise
  logic [RW-1:0]         rb_addr;
  logic [DATA_WIDTH-1:0] ra_data, rb_data, alu_res, rf_wd;
  logic                  rf_we;

  assign rb_addr = ((op == OP_STR) || (op == OP_CBZ)) ? rd_idx : rm_idx;
  assign rf_we   = ((state_q == ST_EXEC) && op_is_alu(op)) || (state_q == ST_MEM);
  assign rf_wd   = (state_q == ST_MEM) ? dmem_rdata_q : alu_res;

  cpu_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NREGS      (NREGS)
  ) u_regfile (
    .clk       (clk),
    .resetn    (resetn),
    .ra_addr_i (rn_idx),
    .ra_data_o (ra_data),
    .rb_addr_i (rb_addr),
    .rb_data_o (rb_data),
    .we_i      (rf_we),
    .wa_i      (rd_idx),
    .wd_i      (rf_wd)
  );

  // ALU result for the register-writing opcodes
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADDI: alu_res = ra_data + imm_ext;
      OP_ADD:  alu_res = ra_data + rb_data;
      OP_SUB:  alu_res = ra_data - rb_data;
      OP_AND:  alu_res = ra_data & rb_data;
      default: alu_res = '0;
    endcase
  end

  // Data address and store strobe; the store is suppressed while in reset
  logic [DW-1:0] dmem_addr;
  logic          dmem_we;

  assign dmem_addr = DW'(ra_data + imm_ext);
  assign dmem_we   = resetn && (state_q == ST_EXEC) && (op == OP_STR);

  // Code store: host writes, plus a registered read of the current pc
  always_ff @(posedge clk) begin
    if (code_we) code_mem[code_waddr] <= code_wdata;
    code_rdata_q <= code_mem[pc_q];
  end

  // Data store: STR write in EXEC, registered read consumed by MEM
  always_ff @(posedge clk) begin
    if (dmem_we) data_mem[dmem_addr] <= rb_data;
    dmem_rdata_q <= data_mem[dmem_addr];
  end

  // Control FSM with pc, instruction and status registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      instr_q   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      load_q    <= '0;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (run) state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          instr_q <= code_rdata_q;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          state_q <= ST_FETCH;
          case (op)
            OP_NOP, OP_ADDI, OP_ADD, OP_SUB, OP_AND, OP_STR: pc_q <= pc_inc;
            OP_B:   pc_q <= pc_b;
            OP_CBZ: pc_q <= (rb_data == '0) ? pc_cbz : pc_inc;
            OP_LDR: state_q <= ST_MEM;
            OP_HALT: begin
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end
            default: begin
              halted_q  <= 1'b1;
              illegal_q <= 1'b1;
              state_q   <= ST_HALT;
            end
          endcase
        end
        ST_MEM: begin
          load_q  <= dmem_rdata_q[7:0];
          pc_q    <= pc_inc;
          state_q <= ST_FETCH;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

`ifdef CPU_MC_RETIRE_CNT_EN
  logic [31:0] retired_q;
  logic        retire;

  // An instruction retires on its last cycle; LDR finishes in MEM
  assign retire = ((state_q == ST_EXEC) && (op != OP_LDR) && !op_is_illegal(op)) ||
                  (state_q == ST_MEM);

  // Free-running wrap-around retirement counter
  always_ff @(posedge clk) begin
    if (!resetn)     retired_q <= '0;
    else if (retire) retired_q <= retired_q + 32'd1;
  end

  assign retired_cnt = retired_q;
`else
  assign retired_cnt = '0;
`endif

  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign led         = pc_q[1];
  assign debug_port1 = 8'(pc_q);
  assign debug_port2 = instr_q[7:0];
  assign debug_port3 = load_q;

endmodule
